// File: rtl/ysyx_25040105_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
// Round-robin arbitration is selected with `define YSYX_25040105_ARB_RR_EN.
package ysyx_25040105_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/ysyx_25040105_arb_pick.sv
// Combinational grant picker between IFU and LSU requests.
// YSYX_25040105_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_25040105_arb_pick
  import ysyx_25040105_pkg::*;
(
  input  logic i_if_valid,
  input  logic i_ls_valid,
`ifdef YSYX_25040105_ARB_RR_EN
  input  logic i_prio,
`endif
  output logic o_grant_if,
  output logic o_grant_ls
);

`ifdef YSYX_25040105_ARB_RR_EN
  // i_prio names the requester that wins a tie: the one that did not own the bus last.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_grant_if = 1'b0;
    o_grant_ls = 1'b0;
    if (i_if_valid && i_ls_valid) begin
      o_grant_ls = (i_prio == OWN_LS);
      o_grant_if = (i_prio == OWN_IF);
    end else begin
      o_grant_ls = i_ls_valid;
      o_grant_if = i_if_valid;
    end
  end
`else
  always_comb begin
    o_grant_ls = i_ls_valid;
    o_grant_if = i_if_valid & ~i_ls_valid;
  end
`endif

endmodule

// File: rtl/ysyx_25040105_mem_arbiter.sv
// Single-port memory arbiter: one outstanding IFU or LSU request, with a bounded WAIT timeout.
// Define YSYX_25040105_ARB_RR_EN for round-robin arbitration (default: LSU fixed priority).
module ysyx_25040105_mem_arbiter
  import ysyx_25040105_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  output logic                if_resp_err,

  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                ls_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,

  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e              r_state;
  state_e              w_state_nxt;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_if_resp_valid;
  logic [DATA_W-1:0]   r_if_resp_data;
  logic                r_if_resp_err;
  logic                r_ls_resp_valid;
  logic [DATA_W-1:0]   r_ls_resp_data;
  logic                r_ls_resp_err;

  logic                w_grant_if;
  logic                w_grant_ls;
  logic                w_idle;
  logic                w_accept;
  logic                w_mem_hs;
  logic                w_resp_hit;
  logic                w_timeout;
  logic                w_done;

`ifdef YSYX_25040105_ARB_RR_EN
  owner_e              r_prio;
`endif

  ysyx_25040105_arb_pick u_pick (
    .i_if_valid (if_req_valid),
    .i_ls_valid (ls_req_valid),
`ifdef YSYX_25040105_ARB_RR_EN
    .i_prio     (r_prio),
`endif
    .o_grant_if (w_grant_if),
    .o_grant_ls (w_grant_ls)
  );

  // Readies are gated by rst so nothing is granted while reset is held.
  assign w_idle       = (r_state == ST_IDLE);
  assign if_req_ready = rst & w_idle & w_grant_if;
  assign ls_req_ready = rst & w_idle & w_grant_ls;
  assign w_accept     = if_req_ready | ls_req_ready;

  assign w_mem_hs   = (r_state == ST_REQ) & mem_req_ready;
  assign w_resp_hit = (r_state == ST_WAIT) & mem_resp_valid;
  assign w_timeout  = (r_state == ST_WAIT) & ~mem_resp_valid & (r_cnt == CNT_MAX);
  assign w_done     = w_resp_hit | w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_mem_hs) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_done)   w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with <= so every register samples pre-edge values in the same step.
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: the latched request is reset too, because it drives the mem port directly and must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      if (ls_req_ready) begin
        r_owner <= OWN_LS;
        r_addr  <= ls_req_addr;
        r_wen   <= ls_req_wen;
        r_wdata <= ls_req_wdata;
        r_wmask <= ls_req_wmask;
      end else begin
        r_owner <= OWN_IF;
        r_addr  <= if_req_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  // Counter saturates at TIMEOUT so the compare stays valid when TIMEOUT is 2^n-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_mem_hs) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A response beats the timeout when both land in the same WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_resp_valid <= 1'b0;
      r_if_resp_data  <= '0;
      r_if_resp_err   <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_ls_resp_data  <= '0;
      r_ls_resp_err   <= 1'b0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      if (w_done) begin
        if (r_owner == OWN_LS) begin
          r_ls_resp_valid <= 1'b1;
          r_ls_resp_data  <= w_resp_hit ? mem_resp_data : '0;
          r_ls_resp_err   <= ~w_resp_hit;
        end else begin
          r_if_resp_valid <= 1'b1;
          r_if_resp_data  <= w_resp_hit ? mem_resp_data : '0;
          r_if_resp_err   <= ~w_resp_hit;
        end
      end
    end
  end

`ifdef YSYX_25040105_ARB_RR_EN
  // Pointer holds the tie-break winner, i.e. whoever was not granted last; LSU after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_prio <= OWN_LS;
    else if (w_accept) r_prio <= ls_req_ready ? OWN_IF : OWN_LS;
  end
`endif

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

  assign if_resp_valid = r_if_resp_valid;
  assign if_resp_data  = r_if_resp_data;
  assign if_resp_err   = r_if_resp_err;
  assign ls_resp_valid = r_ls_resp_valid;
  assign ls_resp_data  = r_ls_resp_data;
  assign ls_resp_err   = r_ls_resp_err;

  assign busy = (r_state != ST_IDLE);

endmodule
